// File: rtl/serial_line_pkg.sv
// Shared types and helpers for the serial line transmitter.
// Optional even-parity bit is enabled by defining SERIAL_LINE_TX_PARITY_EN.
package serial_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Level the line rests at when no frame bit is being driven.
  function automatic logic idle_level(input int invert);
    return (invert != 0);
  endfunction

endpackage

// File: rtl/serial_line_enc.sv
// Line output register for the serial transmitter: drives the raw bit when
// enabled, otherwise the idle level, with polarity fixed at elaboration.
module serial_line_enc
  import serial_line_pkg::*;
#(
  parameter int INVERT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic drive,
  output logic line
);

  logic line_d;
  logic line_q;

  generate
    if (INVERT == 0) begin : g_true
      always_comb begin
        line_d = drive ? raw : idle_level(0);
      end
    end else begin : g_complement
      always_comb begin
        line_d = drive ? ~raw : idle_level(1);
      end
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_q <= idle_level(INVERT);
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/serial_line_tx.sv
// MSB-first serialising transmitter with valid/ready input and registered line.
// Define SERIAL_LINE_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_line_tx
  import serial_line_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int INVERT = 0,
  parameter int GAP    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             line,
  output logic             frame,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  // With no gap configured the frame returns straight to IDLE.
  localparam state_t POST_FRAME = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             enc_raw;
  logic             enc_drive;
`ifdef SERIAL_LINE_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
`ifdef SERIAL_LINE_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          sreg_d  = data_in;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
`ifdef SERIAL_LINE_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      ST_SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
`ifdef SERIAL_LINE_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = POST_FRAME;
          gap_d   = GAP_LOAD;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SERIAL_LINE_TX_PARITY_EN
      ST_PARITY: begin
        state_d = POST_FRAME;
        gap_d   = GAP_LOAD;
        done_d  = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line and frame are registered from the next-state view, so the bit on
  // the line always belongs to the state currently held in state_q.
  always_comb begin
`ifdef SERIAL_LINE_TX_PARITY_EN
    enc_drive = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
    enc_raw   = (state_d == ST_PARITY) ? parity_d : sreg_d[WIDTH-1];
`else
    enc_drive = (state_d == ST_SHIFT);
    enc_raw   = sreg_d[WIDTH-1];
`endif
    frame_d = enc_drive;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_LINE_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      done_q  <= done_d;
`ifdef SERIAL_LINE_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  serial_line_enc #(
    .INVERT(INVERT)
  ) u_enc (
    .clock(clock),
    .reset(reset),
    .raw  (enc_raw),
    .drive(enc_drive),
    .line (line)
  );

  assign ready = (state_q == ST_IDLE);
  assign frame = frame_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_line_tx.sv
// Directed bench for serial_line_tx: three instances (plain, inverted, no gap)
// checked against a per-instance queue of expected line bits.
module tb_serial_line_tx;

`ifdef SERIAL_LINE_TX_PARITY_EN
  localparam int F   = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic [2:0] reset;
  logic [2:0] valid;
  logic [7:0] data_in [3];
  logic [2:0] ready;
  logic [2:0] line;
  logic [2:0] frame;
  logic [2:0] done;

  bit exp_q [3][$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_line_tx #(.WIDTH(8), .INVERT(0), .GAP(1)) dut_plain (
    .clock(clock), .reset(reset[0]), .data_in(data_in[0]), .valid(valid[0]),
    .ready(ready[0]), .line(line[0]), .frame(frame[0]), .done(done[0])
  );

  serial_line_tx #(.WIDTH(8), .INVERT(1), .GAP(1)) dut_inv (
    .clock(clock), .reset(reset[1]), .data_in(data_in[1]), .valid(valid[1]),
    .ready(ready[1]), .line(line[1]), .frame(frame[1]), .done(done[1])
  );

  serial_line_tx #(.WIDTH(8), .INVERT(0), .GAP(0)) dut_b2b (
    .clock(clock), .reset(reset[2]), .data_in(data_in[2]), .valid(valid[2]),
    .ready(ready[2]), .line(line[2]), .frame(frame[2]), .done(done[2])
  );

  function automatic bit inv_of(input int d);
    return (d == 1);
  endfunction

  function automatic int gap_of(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input int d, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) exp_q[d].push_back(w[i] ^ inv_of(d));
    if (PAR) exp_q[d].push_back((^w) ^ inv_of(d));
  endtask

  // One in-frame cycle: compare line against the scoreboard head, then advance.
  task automatic frame_cycle(input int d, input string tag);
    logic e;
    if (exp_q[d].size() == 0) begin
      check({tag, "_underflow"}, 32'd0, 32'd1);
      e = 1'bx;
    end else begin
      e = exp_q[d].pop_front();
    end
    check({tag, "_line"}, line[d], e);
    check({tag, "_frame"}, frame[d], 1'b1);
    check({tag, "_done_in_frame"}, done[d], 1'b0);
    check({tag, "_ready_busy"}, ready[d], 1'b0);
    step();
  endtask

  // Cycle k+F+1 onward: done pulse, idle line, then ready after the gap.
  task automatic frame_tail(input int d, input string tag);
    check({tag, "_done"}, done[d], 1'b1);
    check({tag, "_frame_end"}, frame[d], 1'b0);
    check({tag, "_line_idle"}, line[d], inv_of(d));
    for (int g = 0; g < gap_of(d); g++) begin
      check({tag, "_ready_gap"}, ready[d], 1'b0);
      step();
    end
    if (gap_of(d) > 0) check({tag, "_done_once"}, done[d], 1'b0);
    check({tag, "_ready_back"}, ready[d], 1'b1);
  endtask

  task automatic send(input int d, input logic [7:0] w, input bit poke, input string tag);
    check({tag, "_ready_start"}, ready[d], 1'b1);
    data_in[d] = w;
    valid[d]   = 1'b1;
    push_word(d, w);
    step();
    valid[d]   = 1'b0;
    data_in[d] = ~w;
    for (int j = 0; j < F; j++) begin
      if (poke && j == 2) begin
        valid[d]   = 1'b1;
        data_in[d] = 8'h3C;
      end
      if (poke && j == 3) valid[d] = 1'b0;
      frame_cycle(d, tag);
    end
    frame_tail(d, tag);
  endtask

  initial begin
    reset = 3'b111;
    valid = 3'b000;
    for (int d = 0; d < 3; d++) data_in[d] = 8'h00;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", ready[d], 1'b1);
      check("rst_line", line[d], inv_of(d));
      check("rst_frame", frame[d], 1'b0);
      check("rst_done", done[d], 1'b0);
    end
    reset = 3'b000;
    step();

    send(0, 8'hA5, 1'b0, "basic");
    send(1, 8'hA5, 1'b0, "inverted");

    // Mid-frame valid with 0x3C must neither disturb nor queue a frame.
    send(0, 8'hC3, 1'b1, "ignored");
    for (int i = 0; i < 3; i++) begin
      check("ignored_no_frame", frame[0], 1'b0);
      step();
    end

    // Back-to-back on the gapless instance with valid held high.
    check("b2b_ready_start", ready[2], 1'b1);
    data_in[2] = 8'hFF;
    valid[2]   = 1'b1;
    push_word(2, 8'hFF);
    step();
    data_in[2] = 8'h00;
    push_word(2, 8'h00);
    for (int j = 0; j < F; j++) frame_cycle(2, "b2b_first");
    check("b2b_done1", done[2], 1'b1);
    check("b2b_idle_bit", line[2], 1'b0);
    check("b2b_frame_gap", frame[2], 1'b0);
    check("b2b_ready_mid", ready[2], 1'b1);
    step();
    valid[2] = 1'b0;
    for (int j = 0; j < F; j++) frame_cycle(2, "b2b_second");
    frame_tail(2, "b2b_second");

    // Reset while bit 4 is on the line.
    data_in[0] = 8'h55;
    valid[0]   = 1'b1;
    push_word(0, 8'h55);
    step();
    valid[0] = 1'b0;
    for (int j = 0; j < 3; j++) frame_cycle(0, "abort");
    reset[0] = 1'b1;
    step();
    reset[0] = 1'b0;
    exp_q[0].delete();
    check("abort_line", line[0], 1'b0);
    check("abort_frame", frame[0], 1'b0);
    check("abort_ready", ready[0], 1'b1);
    check("abort_done", done[0], 1'b0);
    step();
    check("abort_done_after", done[0], 1'b0);
    check("abort_frame_after", frame[0], 1'b0);

    // Reset and valid together: nothing is accepted.
    reset[0]   = 1'b1;
    valid[0]   = 1'b1;
    data_in[0] = 8'hF0;
    step();
    reset[0] = 1'b0;
    valid[0] = 1'b0;
    check("rstvalid_ready", ready[0], 1'b1);
    check("rstvalid_frame", frame[0], 1'b0);
    step();
    check("rstvalid_frame_next", frame[0], 1'b0);
    check("rstvalid_ready_next", ready[0], 1'b1);

    send(0, 8'h81, 1'b0, "after_reset");
    send(0, 8'h07, 1'b0, "parity_plain");
    send(1, 8'h07, 1'b0, "parity_inv");
    send(2, 8'h5A, 1'b0, "nogap");

    for (int d = 0; d < 3; d++) check("scoreboard_empty", exp_q[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_line_tx.md
# serial_line_tx

Serialising transmitter that drives a single-bit line sampled on each rising edge of `clock` by the capture-side receiver. It accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, with optional line inversion selected at elaboration. It sits upstream of the bit-capture receiver and, optionally, adds an even-parity bit after the data.

## Interface
- `WIDTH`, 8, data word width; must be at least 2.
- `INVERT`, 0, 0 drives the line true, 1 drives it complemented; the choice is made by a generate branch.
- `GAP`, 1, number of idle cycles inserted after each frame; may be 0.

- `clock` in 1: single clock; all logic uses the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in WIDTH: word to send; sampled only at acceptance.
- `valid` in 1: a word is offered.
- `ready` out 1: the block can accept a word; high only in IDLE.
- `line` out 1: registered serial output.
- `frame` out 1: registered; high while a data or parity bit is on `line`.
- `done` out 1: registered one-cycle pulse after the last bit of a frame.

## Operation
- Reset values:
  - state IDLE, so `ready`=1.
  - `line` is at the idle level: 0 if `INVERT`=0, 1 if `INVERT`=1.
  - `frame`=0 and `done`=0.
- **IDLE:** acceptance happens when `valid & ready` are high at an edge. At that edge:
  - `data_in` loads the shift register.
  - The bit counter loads WIDTH-1.
  - State moves to SHIFT.
- **SHIFT:** `line` carries the shift-register MSB, XORed with INVERT. The register shifts left each cycle and the counter decrements. At counter 0, state moves to PARITY if the macro is enabled; otherwise it moves to GAP, or to IDLE when GAP=0.
- **PARITY (macro only):** `line` carries the XOR-reduction of the captured word, XORed with INVERT. This lasts one cycle, then state moves to GAP or IDLE as above.
- **GAP:** a gap counter loaded with GAP-1 counts down to 0, then state moves to IDLE. `line` is at the idle level.
- **`done`:** pulses in the first cycle after the final frame bit. This cycle is the first GAP cycle, or the first IDLE cycle when GAP=0.
- **Handshake rules:**
  - `valid` while `ready`=0 is ignored; there is no queuing.
  - `data_in` changes after acceptance do not affect the frame in flight.
- **Widths:**
  - Bit counter: $clog2(WIDTH) bits.
  - Gap counter: $clog2(GAP+1) bits, or 1 bit minimum.
  - No arithmetic overflow is possible; counters only decrement from their load values to 0.

## Timing
- Acceptance occurs at edge k.
- Bit WIDTH-1 is on `line` in cycle k+1. Bit i is on `line` in cycle k+1+(WIDTH-1-i).
- `frame`=1 in cycles k+1 through k+F, where F = WIDTH (+1 when parity is enabled).
- `done`=1 in cycle k+F+1 only.
- `ready` returns high in cycle k+F+1+GAP.
- The next acceptance is possible at the end of that cycle, so the minimum frame spacing is F+1+GAP cycles.
- Reset asserted in any state takes effect at that edge. The next cycle shows the reset values. The aborted frame produces no `done`.
- Reset and `valid` asserted together: reset wins and nothing is accepted.

## Configuration
- `SERIAL_LINE_TX_PARITY_EN` defined:
  - The PARITY state exists.
  - F = WIDTH+1.
  - The parity bit is the even parity of the word, inverted when INVERT=1.
- Macro undefined:
  - No PARITY state and no parity logic.
  - F = WIDTH.

## Structure
- **Shared package `serial_line_pkg`:**
  - state enum: IDLE, SHIFT, PARITY, GAP.
  - idle-level function of INVERT.
- **Sub-module `serial_line_enc`:**
  - Registers `line` from the raw bit plus a `drive` enable.
  - Holds the generate-if on INVERT: a true branch and a complemented branch.
  - Is instantiated once.

## Test plan
- **Basic frame:** WIDTH=8, INVERT=0, GAP=1, send 0xA5.
  - `line` is 1,0,1,0,0,1,0,1 in cycles k+1..k+8.
  - `frame` is high for those 8 cycles; `done` is high at k+9; `ready` rises at k+10.
- **Inverted frame:** INVERT=1, send 0xA5.
  - `line` is 0,1,0,1,1,0,1,0; the idle level before and after is 1.
- **Back-to-back:** GAP=0, `valid` held high with 0xFF then 0x00.
  - The second word is accepted at edge k+9.
  - `line` shows eight 1s, one idle 0, then eight 0s; `done` pulses twice.
- **Ignored valid:** change `data_in` to 0x3C and pulse `valid` mid-frame.
  - The frame in flight is unchanged.
  - 0x3C is never sent unless it is re-offered while `ready`=1.
- **Reset mid-frame:** assert `reset` at bit 4.
  - The next cycle has `line` at the idle level, `frame`=0, `ready`=1, and no `done`.
  - A subsequent 0x81 is sent correctly.
- **Parity (macro defined):** send 0x07.
  - The ninth bit is 1 and `done` is at k+10.
  - With INVERT=1 the ninth bit is 0.
